// File: rtl/gb_map_pkg.sv
// Shared gray-balance definitions: default gray-level width and map-builder state encoding.
package gb_map_pkg;

   localparam int unsigned GB_DATA_WIDTH = 14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } gb_state_t;

endpackage

// File: rtl/gb_map_if.sv
// Map-builder bus: control handshake, occupancy-bitmap read/clear port and mapping-table write port.
interface gb_map_if
   import gb_map_pkg::*;
#(
   parameter int unsigned DW = GB_DATA_WIDTH
) ();

   logic          start;
   logic [DW:0]   stat_cnt;
   logic [DW-1:0] occ_rd_addr;
   logic          occ_rd_q;
   logic [DW-1:0] occ_clr_addr;
   logic          occ_clr;
   logic [DW-1:0] lut_addr;
   logic [DW-1:0] lut_data;
   logic          lut_write;
   logic          busy;
   logic          done;
   logic          cnt_err;

   modport slave (
      input  start, stat_cnt, occ_rd_q,
      output occ_rd_addr, occ_clr_addr, occ_clr, lut_addr, lut_data, lut_write,
             busy, done, cnt_err
   );

   modport master (
      output start, stat_cnt, occ_rd_q,
      input  occ_rd_addr, occ_clr_addr, occ_clr, lut_addr, lut_data, lut_write,
             busy, done, cnt_err
   );

endinterface

// File: rtl/gb_map_scan.sv
// Bitmap address sweep 0..2^DW-1 plus a one-cycle delayed valid/address matching the read latency.
module gb_map_scan
   import gb_map_pkg::*;
#(
   parameter int unsigned DW = GB_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   output logic [DW-1:0] o_rd_addr,
   output logic          o_last,
   output logic          o_vld,
   output logic [DW-1:0] o_addr_d
);

   localparam logic [DW-1:0] ADDR_MAX = {DW{1'b1}};

   logic          r_active;
   logic [DW-1:0] r_addr;
   logic          r_vld;
   logic [DW-1:0] r_addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_addr   <= '0;
         r_vld    <= 1'b0;
         r_addr_d <= '0;
      end else begin
         r_vld    <= r_active;
         r_addr_d <= r_addr;
         if (i_start) begin
            r_active <= 1'b1;
            r_addr   <= '0;
         end else if (r_active) begin
            // counter wraps to 0 on the last address and stops issuing
            r_addr <= r_addr + DW'(1);
            if (r_addr == ADDR_MAX) r_active <= 1'b0;
         end
      end
   end

   assign o_rd_addr = r_addr;
   assign o_last    = r_active && (r_addr == ADDR_MAX);
   assign o_vld     = r_vld;
   assign o_addr_d  = r_addr_d;

endmodule

// File: rtl/gb_map.sv
// Gray-balance map builder: sweeps the occupancy bitmap, writes each level's rank into the
// mapping table, clears occupied bits and compares the final count with the statistics count.
module gb_map
   import gb_map_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GB_DATA_WIDTH
) (
   input  logic     clk,
   input  logic     rst,
   gb_map_if.slave  bus
);

   localparam int unsigned CW = DATA_WIDTH + 1;

   gb_state_t             r_state;
   gb_state_t             w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_stat;
   logic                  r_cnt_err;
   logic                  w_accept;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_last;
   logic                  w_vld;
   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_addr_d;
   logic [CW-1:0]         w_cnt_new;

   gb_map_scan #(.DW(DATA_WIDTH)) u_scan (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_accept),
      .o_rd_addr (w_rd_addr),
      .o_last    (w_last),
      .o_vld     (w_vld),
      .o_addr_d  (w_addr_d)
   );

   assign w_accept  = (r_state == ST_IDLE) && bus.start;
   assign w_hit     = w_vld && bus.occ_rd_q;
   assign w_cnt_new = r_cnt + CW'(w_hit);

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_nxt = ST_SCAN;
         ST_SCAN: begin
            w_busy = 1'b1;
            if (w_last) w_state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            w_busy      = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_stat    <= '0;
         r_cnt_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_stat    <= bus.stat_cnt;
            r_cnt     <= '0;
            r_cnt_err <= 1'b0;
         end else begin
            if (w_vld) r_cnt <= w_cnt_new;
            // FLUSH carries the last bitmap bit, so w_cnt_new is the final count here
            if (r_state == ST_FLUSH) r_cnt_err <= (w_cnt_new != r_stat);
         end
      end
   end

   assign bus.occ_rd_addr  = w_rd_addr;
   assign bus.occ_clr      = w_hit;
   assign bus.occ_clr_addr = w_addr_d;
   assign bus.lut_write    = w_vld;
   assign bus.lut_addr     = w_addr_d;
   assign bus.lut_data     = (w_vld && (w_cnt_new != '0)) ? DATA_WIDTH'(w_cnt_new - CW'(1)) : '0;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.cnt_err      = r_cnt_err;

endmodule

// File: tb/tb_gb_map.sv
// Scoreboard bench for gb_map at DATA_WIDTH=4: directed and random bitmaps against a rank model.
module tb_gb_map;
   import gb_map_pkg::*;

   localparam int unsigned DW = 4;
   localparam int unsigned N  = 16;
   localparam longint      T_DONE = 175;

   typedef struct {
      int addr;
      int data;
      bit clr;
   } wr_t;

   typedef struct {
      bit     err;
      longint t;
   } dn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gb_map_if #(.DW(DW)) bus ();

   gb_map #(.DATA_WIDTH(DW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // occupancy bitmap RAM model: synchronous read, clear strobe, bulk load from stimulus
   logic [N-1:0] occ = '0;
   logic         load_req = 1'b0;
   logic [N-1:0] load_val = '0;
   always @(posedge clk) begin
      if (load_req) occ <= load_val;
      else if (bus.occ_clr) occ[bus.occ_clr_addr] <= 1'b0;
      bus.occ_rd_q <= occ[bus.occ_rd_addr];
   end

   wr_t exp_wr[$];
   dn_t exp_dn[$];
   int  total = 0;
   int  bad   = 0;
   bit  chk_idle  = 1'b0;
   bit  chk_final = 1'b0;

   function automatic void chk(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endfunction

   // monitor: pops expectations whenever the DUT presents a write or a done
   always @(negedge clk) begin
      wr_t e;
      dn_t d;
      if (bus.lut_write) begin
         if (exp_wr.size() == 0) chk("unexpected_lut_write", longint'(bus.lut_write), 0);
         else begin
            e = exp_wr.pop_front();
            chk("lut_addr", longint'(bus.lut_addr), e.addr);
            chk("lut_data", longint'(bus.lut_data), e.data);
            chk("occ_clr", longint'(bus.occ_clr), longint'(e.clr));
            if (e.clr) chk("occ_clr_addr", longint'(bus.occ_clr_addr), e.addr);
            chk("busy_in_run", longint'(bus.busy), 1);
         end
      end else begin
         chk("occ_clr_without_write", longint'(bus.occ_clr), 0);
      end
      if (bus.done) begin
         if (exp_dn.size() == 0) chk("unexpected_done", longint'(bus.done), 0);
         else begin
            d = exp_dn.pop_front();
            chk("done_time", longint'($time), d.t);
            chk("cnt_err", longint'(bus.cnt_err), longint'(d.err));
            chk("writes_before_done", longint'(exp_wr.size()), 0);
         end
      end
      if (chk_idle) begin
         chk("idle_busy", longint'(bus.busy), 0);
         chk("idle_done", longint'(bus.done), 0);
         chk("idle_lut_write", longint'(bus.lut_write), 0);
         chk("idle_occ_clr", longint'(bus.occ_clr), 0);
         chk("idle_cnt_err", longint'(bus.cnt_err), 0);
         chk("idle_rd_addr", longint'(bus.occ_rd_addr), 0);
         chk("idle_lut_addr", longint'(bus.lut_addr), 0);
         chk("idle_lut_data", longint'(bus.lut_data), 0);
      end
      if (chk_final) begin
         chk("pending_writes", longint'(exp_wr.size()), 0);
         chk("pending_done", longint'(exp_dn.size()), 0);
      end
   end

   // one run: rank model computed from the bitmap; optional ignored start or mid-run reset
   task automatic run(input logic [N-1:0] bm, input int stat, input int extra_at, input int rst_at);
      int     c;
      int     lim;
      longint e0;
      wr_t    w;
      dn_t    d;
      c   = 0;
      lim = (rst_at > 0) ? rst_at - 1 : int'(N);
      for (int a = 0; a < int'(N); a++) begin
         if (bm[a]) c++;
         if (a < lim) begin
            w.addr = a;
            w.data = (c == 0) ? 0 : c - 1;
            w.clr  = bm[a];
            exp_wr.push_back(w);
         end
      end
      @(negedge clk);
      load_req = 1'b1;
      load_val = bm;
      @(negedge clk);
      load_req     = 1'b0;
      bus.start    = 1'b1;
      bus.stat_cnt = 5'(stat);
      @(posedge clk);
      e0 = $time;
      if (rst_at == 0) begin
         d.err = ($countones(bm) != stat);
         d.t   = e0 + T_DONE;
         exp_dn.push_back(d);
      end
      #1;
      bus.start    = 1'b0;
      bus.stat_cnt = 5'($urandom_range(0, 16));
      if (extra_at > 0) begin
         repeat (extra_at - 1) @(posedge clk);
         @(negedge clk);
         bus.start = 1'b1;
         @(posedge clk);
         #1 bus.start = 1'b0;
      end
      if (rst_at > 0) begin
         repeat (rst_at - 1) @(posedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1 chk_idle = 1'b1;
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         @(posedge clk);
         #1 chk_idle = 1'b0;
      end else begin
         repeat (20 - extra_at) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [N-1:0] bm;
      int           st;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.stat_cnt = '0;
      repeat (2) @(posedge clk);
      #1 chk_idle = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_idle = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      run(16'h0224, 3, 0, 0);          // levels 2,5,9
      run(16'hFFFF, 16, 0, 0);         // all levels
      run(16'h0000, 1, 0, 0);          // empty bitmap, count mismatch
      run(16'h0224, 3, 5, 0);          // second start ignored
      run(16'h0224, 3, 0, 8);          // mid-run reset
      run(16'h8421, 4, 0, 0);          // full run after reset
      run(16'h0001, 1, 0, 0);          // back-to-back with {0}
      for (int i = 0; i < 6; i++) begin
         bm = N'($urandom);
         st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : $countones(bm);
         run(bm, st, 0, 0);
      end

      #1 chk_final = 1'b1;
      @(posedge clk);
      #1 chk_final = 1'b0;
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gb_map.md
GB_MAP -- requirements
Module: gb_map

Interface
REQ-001 Parameter DATA_WIDTH, default 14, gray-level width; table depth is 2^DATA_WIDTH.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  one-cycle request to build the map (driven from frame end of the statistics block).
REQ-006 stat_cnt  in  DATA_WIDTH+1  distinct-level count from the statistics block, latched on accepted start.
REQ-007 occ_rd_addr  out  DATA_WIDTH  occupancy-bitmap read address.
REQ-008 occ_rd_q  in  1  occupancy bit, valid exactly one cycle after occ_rd_addr.
REQ-009 occ_clr_addr  out  DATA_WIDTH  bitmap clear address (write data is implicitly 0).
REQ-010 occ_clr  out  1  bitmap clear strobe.
REQ-011 lut_addr  out  DATA_WIDTH  mapping-table write address.
REQ-012 lut_data  out  DATA_WIDTH  mapped output level.
REQ-013 lut_write  out  1  mapping-table write strobe.
REQ-014 busy  out  1  high from the cycle after accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 cnt_err  out  1  sticky mismatch flag, valid from done until the next accepted start.

Function
REQ-017 States: IDLE, SCAN, FLUSH, DONE; all other encodings return to IDLE.
REQ-018 IDLE->SCAN when start=1; latch stat_cnt, clear the running count, clear cnt_err, and set the read address to 0.
REQ-019 SCAN presents occ_rd_addr = 0,1,...,2^DATA_WIDTH-1 on consecutive cycles, one address per cycle, with no stalls.
REQ-020 SCAN->FLUSH after the cycle presenting address 2^DATA_WIDTH-1; the address counter wraps to 0 and does not re-issue.
REQ-021 FLUSH->DONE after one cycle; DONE->IDLE after one cycle; done=1 only in DONE.
REQ-022 For each address a, one cycle after it is presented: occ_rd_q=1 increments the running count cnt (width DATA_WIDTH+1).
REQ-023 In that same cycle, lut_write=1 with lut_addr=a and lut_data = (cnt_new==0) ? 0 : cnt_new-1, where cnt_new includes a's bit.
REQ-024 Mapping rule: each occupied level maps to its 0-based rank; each unoccupied level maps to the rank of the nearest lower occupied level, or 0 if none exists.
REQ-025 In that same cycle, occ_clr=1 with occ_clr_addr=a when occ_rd_q=1; the strobe is 0 for unoccupied addresses.
REQ-026 Exactly 2^DATA_WIDTH lut writes occur per run, in ascending address order.
REQ-027 Latency: start at edge E0 gives lut_write in cycles E0+2 .. E0+2^DATA_WIDTH+1 and done in cycle E0+2^DATA_WIDTH+2.
REQ-028 In DONE, cnt_err = (final cnt != latched stat_cnt).
REQ-029 start while busy or in DONE is ignored, with no queuing; start in the same cycle that done is high is also ignored.
REQ-030 The all-levels-occupied case yields cnt=2^DATA_WIDTH with no overflow, and lut_data maxes at 2^DATA_WIDTH-1.
REQ-031 Empty bitmap: every lut_data is 0, there are no occ_clr strobes, and cnt_err=1 iff stat_cnt!=0.

Reset
REQ-032 rst=1 forces IDLE; busy, done, lut_write, occ_clr and cnt_err are 0; all addresses, cnt and the latched count are 0.
REQ-033 rst mid-run aborts immediately: there are no further strobes and no done pulse, and a partially cleared bitmap is the caller's responsibility.
REQ-034 After release, the block accepts start on the first cycle.

Structure
REQ-035 The state encoding and DATA_WIDTH default live in the shared gray-balance package, also used by the statistics block.
REQ-036 One sub-module, gb_map_scan (address counter plus one-cycle read-valid/address delay pipeline), is instantiated; FSM and rank logic stay in gb_map.

Verification (DATA_WIDTH=4, 16 levels)
REQ-037 Levels {2,5,9} set, stat_cnt=3, start -> lut = 0,0,0,0,0,1,1,1,1,2,2,2,2,2,2,2 at addresses 0..15; occ_clr at 2,5,9 only; cnt_err=0; done at E0+18.
REQ-038 All 16 levels set, stat_cnt=16 -> lut[a]=a; 16 occ_clr strobes; cnt_err=0.
REQ-039 Empty bitmap, stat_cnt=1 -> all lut_data=0; no occ_clr; cnt_err=1.
REQ-040 Second start pulsed at E0+5 during a run -> ignored: a single done at E0+18 and exactly 16 lut writes.
REQ-041 rst asserted at E0+8 -> no lut_write, occ_clr or done from the next cycle; outputs at reset values; a new start then runs a full 18-cycle sequence.
REQ-042 Two back-to-back runs, with the bitmap repopulated to {0} between them -> second lut: all 0; cnt=1; cnt_err reflects only the second run.
